cond_exec_ctrl: RTL and testbench

COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

---
 rtl/cond_pkg.sv | 32 +++
 rtl/cond_exec_ctrl_eval.sv | 40 ++++
 rtl/cond_exec_ctrl.sv | 81 ++++++++
 tb/tb_cond_exec_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types for conditional-execution control: condition codes,
// squash FSM states and NZCV bit positions.
package cond_pkg;

  localparam logic [3:0] EQ = 4'b0000;
  localparam logic [3:0] NE = 4'b0001;
  localparam logic [3:0] CS = 4'b0010;
  localparam logic [3:0] CC = 4'b0011;
  localparam logic [3:0] MI = 4'b0100;
  localparam logic [3:0] PL = 4'b0101;
  localparam logic [3:0] VS = 4'b0110;
  localparam logic [3:0] VC = 4'b0111;
  localparam logic [3:0] HI = 4'b1000;
  localparam logic [3:0] LS = 4'b1001;
  localparam logic [3:0] GE = 4'b1010;
  localparam logic [3:0] LT = 4'b1011;
  localparam logic [3:0] GT = 4'b1100;
  localparam logic [3:0] LE = 4'b1101;
  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

endpackage

// File: rtl/cond_exec_ctrl_eval.sv
// Combinational condition evaluator: maps a 4-bit condition
// field and the NZCV flags to cond_true.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = nzcv[N_IDX];
  assign z = nzcv[Z_IDX];
  assign c = nzcv[C_IDX];
  assign v = nzcv[V_IDX];

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      EQ: cond_true = z;
      NE: cond_true = !z;
      CS: cond_true = c;
      CC: cond_true = !c;
      MI: cond_true = n;
      PL: cond_true = !n;
      VS: cond_true = v;
      VC: cond_true = !v;
      HI: cond_true = c & !z;
      LS: cond_true = !c | z;
      GE: cond_true = (n == v);
      LT: cond_true = (n != v);
      GT: cond_true = !z & (n == v);
      LE: cond_true = z | (n != v);
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_ctrl.sv
// Conditional-execution and branch-squash control for the EX stage.
// Optional annul counter enabled by COND_ANNUL_CNT_EN.
module cond_exec_ctrl
  import cond_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_cond,
  input  logic             ex_s,
  input  logic             ex_is_br,
  input  logic [3:0]       alu_nzcv,
  input  logic             stall,
  output logic             exec_en,
  output logic             br_taken,
  output logic             flush,
  output logic [3:0]       sr_nzcv,
  output logic [CNT_W-1:0] annul_cnt
);

  state_t     state;
  logic [2:0] sq_cnt;
  logic       cond_true;

  cond_eval u_eval (
    .nzcv      (sr_nzcv),
    .cond      (ex_cond),
    .cond_true (cond_true)
  );

  assign exec_en  = ex_valid & cond_true & !stall
                  & (state == RUN);
  assign br_taken = exec_en & ex_is_br;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      sq_cnt  <= 3'd0;
      flush   <= 1'b0;
      sr_nzcv <= 4'b0000;
    end else if (!stall) begin
      if (exec_en && ex_s)
        sr_nzcv <= alu_nzcv;
      unique case (state)
        RUN: begin
          if (br_taken) begin
            state  <= SQUASH;
            sq_cnt <= 3'(FLUSH_CYCLES);
            flush  <= 1'b1;
          end
        end
        SQUASH: begin
          sq_cnt <= sq_cnt - 3'd1;
          if (sq_cnt == 3'd1) begin
            state <= RUN;
            flush <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef COND_ANNUL_CNT_EN
  logic annulled;

  assign annulled = ex_valid & !stall & !exec_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      annul_cnt <= '0;
    else if (annulled && annul_cnt != '1)
      annul_cnt <= annul_cnt + 1'b1;
  end
`else
  assign annul_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Scoreboard bench for cond_exec_ctrl: directed scenarios plus
// random traffic against a cycle-level reference model.
module tb_cond_exec_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 16;
  localparam int MAXA = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic [3:0]    ex_cond = 4'd0;
  logic          ex_s = 1'b0;
  logic          ex_is_br = 1'b0;
  logic [3:0]    alu_nzcv = 4'd0;
  logic          stall = 1'b0;
  logic          exec_en;
  logic          br_taken;
  logic          flush;
  logic [3:0]    sr_nzcv;
  logic [CW-1:0] annul_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          ex;
    logic          bt;
    logic          fl;
    logic [3:0]    sr;
    logic [CW-1:0] ac;
  } exp_t;

  exp_t q[$];

  logic [3:0] m_sr = 4'd0;
  int         m_left = 0;
  int         m_annul = 0;

  cond_exec_ctrl #(
    .FLUSH_CYCLES(FC),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_cond   (ex_cond),
    .ex_s      (ex_s),
    .ex_is_br  (ex_is_br),
    .alu_nzcv  (alu_nzcv),
    .stall     (stall),
    .exec_en   (exec_en),
    .br_taken  (br_taken),
    .flush     (flush),
    .sr_nzcv   (sr_nzcv),
    .annul_cnt (annul_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Condition pairs: odd codes are the negation of the even code below.
  function automatic logic cond_ok(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [CW-1:0] exp_annul();
`ifdef COND_ANNUL_CNT_EN
    return CW'(m_annul);
`else
    return '0;
`endif
  endfunction

  task automatic cyc(logic v, logic [3:0] c, logic s,
                     logic br, logic [3:0] f, logic st);
    exp_t e;
    logic ex;
    @(posedge clk);
    #1;
    ex_valid = v; ex_cond = c; ex_s = s;
    ex_is_br = br; alu_nzcv = f; stall = st;
    ex = v && cond_ok(c, m_sr) && !st && (m_left == 0);
    e.ex = ex;
    e.bt = ex && br;
    e.fl = (m_left > 0);
    e.sr = m_sr;
    e.ac = exp_annul();
    q.push_back(e);
    if (!st) begin
      if (ex && s) m_sr = f;
      if (m_left > 0) m_left--;
      else if (ex && br) m_left = FC;
      if (v && !ex && m_annul < MAXA) m_annul++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("exec_en", 32'(exec_en), 32'(e.ex));
      chk("br_taken", 32'(br_taken), 32'(e.bt));
      chk("flush", 32'(flush), 32'(e.fl));
      chk("sr_nzcv", 32'(sr_nzcv), 32'(e.sr));
      chk("annul_cnt", 32'(annul_cnt), 32'(e.ac));
    end
  end

  initial begin
    #3;
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_sr", 32'(sr_nzcv), 32'd0);
    chk("rst_annul", 32'(annul_cnt), 32'd0);
    chk("rst_exec", 32'(exec_en), 32'd0);
    #4 rst = 1'b0;

    // flag update then EQ sees Z
    cyc(1, 4'b1110, 1, 0, 4'b0100, 0);
    cyc(1, 4'b0000, 0, 0, 4'b0000, 0);
    // taken branch, two AL annulled
    cyc(1, 4'b1110, 0, 1, 4'b0000, 0);
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1110, 0, 1, 4'b0000, 0);
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);
    // clear Z, EQ branch not taken
    cyc(1, 4'b1110, 1, 0, 4'b0000, 0);
    cyc(1, 4'b0000, 0, 1, 4'b0000, 0);
    cyc(0, 4'b1110, 0, 0, 4'b0000, 0);
    // stall held during squash
    cyc(1, 4'b1110, 0, 1, 4'b0000, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 4'b1110, 0, 0, 4'b0000, 1);
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);
    // signed compares with N=1 V=1
    cyc(1, 4'b1110, 1, 0, 4'b1001, 0);
    cyc(1, 4'b1010, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1100, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1011, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1101, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1111, 0, 0, 4'b0000, 0);
    // reset pulse one cycle after a taken branch
    cyc(1, 4'b1110, 0, 1, 4'b0000, 0);
    @(posedge clk);
    #1;
    ex_valid = 0; ex_is_br = 0; stall = 0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_flush", 32'(flush), 32'd0);
    chk("midrst_sr", 32'(sr_nzcv), 32'd0);
    chk("midrst_annul", 32'(annul_cnt), 32'd0);
    #2 rst = 1'b0;
    m_sr = 4'd0; m_left = 0; m_annul = 0;
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);
    cyc(1, 4'b1110, 0, 0, 4'b0000, 0);

    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)),
          1'($urandom_range(0, 4) == 0));
    cyc(0, 4'b1110, 0, 0, 4'b0000, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
